vote_tally_sequencer: RTL and testbench
=======================================

// Module: vote_tally_sequencer
// PURPOSE
//  Sequential tallier/scheduler for the voting datapath. Accepts one candidate
//  vote per cycle over a valid/ready handshake and keeps per-candidate counters.
//  On close, it walks the counters one candidate per cycle and reports the
//  winner. One shared comparator replaces the per-voter adder tree and
//  combinational auction.
// PARAMETERS
//  N  2  candidate index width; 2**N candidates
//  M  2  voter index width; at most 2**M votes per election; counters are M+1 bits
// PORTS
//  clk        in   1    single clock; all state updates on rising edge
//  rst        in   1    asynchronous, active-high reset
//  vote_valid in   1    vote present on vote
//  vote       in   N    candidate index being voted for
//  vote_ready out  1    block can accept a vote this cycle
//  close      in   1    end collection; start winner scan
//  start      in   1    clear tallies; begin a new election (honoured in DONE only)
//  busy       out  1    scan in progress
//  done       out  1    result valid; held until start or rst
//  winner     out  N    winning candidate index
//  win_count  out  M+1  votes received by winner
//  total      out  M+1  votes accepted this election
// BEHAVIOUR
//  Reset (async, any state): state=COLLECT; all counters, total, winner, win_count=0;
//   done=0; busy=0; scan index=0; vote_ready=1 after release.
//  States:
//   COLLECT: vote_ready = (total < 2**M).
//     - Accept when vote_valid & vote_ready: count[vote]++, total++.
//     - vote_valid while vote_ready=0: dropped, no state change.
//     - close -> SCAN. A vote accepted in the same cycle as close is counted.
//   SCAN: busy=1; vote_ready=0; close and start ignored.
//     - Entry: best=0, best_cnt=0, idx=0.
//     - Each cycle: if count[idx] > best_cnt (strict) then best=idx,
//       best_cnt=count[idx]; then idx++.
//     - Compare is strict, so ties go to the lowest index.
//     - After idx=2**N-1 is compared -> DONE.
//   DONE: done=1, busy=0.
//     - winner/win_count/total stable.
//     - start -> COLLECT with all counters and total cleared, done=0 the
//       following cycle.
//     - vote_valid and close ignored.
//  Latency: close sampled in cycle t -> busy high cycles t+1..t+2**N;
//   done high from t+2**N+1.
//  Width: counters cannot overflow. total <= 2**M fits in M+1 bits, and the
//   vote_ready gate enforces the cap.
//  Zero votes: scan still runs full length; winner=0, win_count=0.
//  winner/win_count change only on the SCAN->DONE transition and on rst/start.
// CONFIGURATION
//  VOTE_TIE_FLAG_EN defined:
//   - Adds output port tie (1 bit).
//   - During SCAN, tie is set when count[idx] == best_cnt with best_cnt != 0.
//   - tie is cleared when a strictly larger count is found.
//   - tie is valid with done; reset/start value 0.
//  VOTE_TIE_FLAG_EN undefined: port and logic absent; all other behaviour identical.
// TESTING (N=2, M=2)
//  1. Reset: rst pulse -> winner=0, win_count=0, total=0, done=0, busy=0, vote_ready=1.
//  2. Votes 1,1,2,3 back-to-back, then close -> busy for 4 cycles, then done=1,
//     winner=1, win_count=2, total=4.
//  3. Capacity: votes 0,0,0,0 accepted; 5th vote (3) held valid -> vote_ready=0,
//     count[3]=0, total=4; close -> winner=0, win_count=4.
//  4. Tie: votes 3,2,2,3 then close -> winner=2, win_count=2;
//     tie=1 with VOTE_TIE_FLAG_EN.
//  5. Vote 2 and close in the same cycle with no prior votes -> winner=2,
//     win_count=1, total=1. Then start -> total=0, done=0, vote_ready=1.
//  6. rst asserted during 2nd SCAN cycle -> busy=0 and counters=0 immediately;
//     done stays 0; next votes tally from zero.

Source files
------------

// File: rtl/vote_tally_sequencer.sv
// -----------------------------------------------------------------------------
// vote_tally_sequencer
//
// Sequential vote tallier and winner scheduler. The block takes one candidate
// vote per cycle over a valid/ready handshake and keeps one counter per
// candidate. On close it steps through the counters, one candidate per cycle,
// using a single shared comparator. It then reports the winner, the winner's
// vote count and the total number of votes.
//
// Parameters
//   N : candidate index width (2**N candidates)
//   M : voter index width (at most 2**M votes per election; counters M+1 bits)
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   vote_valid in   1    a vote is present on vote
//   vote       in   N    candidate index being voted for
//   vote_ready out  1    a vote can be accepted this cycle
//   close      in   1    end collection and start the winner scan
//   start      in   1    clear tallies and begin a new election (DONE only)
//   busy       out  1    scan in progress
//   done       out  1    result valid; held until start or rst
//   winner     out  N    winning candidate index (ties go to the lowest index)
//   win_count  out  M+1  votes received by the winner
//   total      out  M+1  votes accepted this election
//   tie        out  1    only with VOTE_TIE_FLAG_EN: another candidate matched
//                        the winning count (valid with done)
//
// Configuration macro: VOTE_TIE_FLAG_EN (adds the tie output and its logic)
// -----------------------------------------------------------------------------
module vote_tally_sequencer #(
    parameter int N = 2,
    parameter int M = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vote_valid,
    input  logic [N-1:0] vote,
    output logic         vote_ready,
    input  logic         close,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [M:0]   win_count,
`ifdef VOTE_TIE_FLAG_EN
    output logic [M:0]   total,
    output logic         tie
`else
    output logic [M:0]   total
`endif
);

    localparam int unsigned NCAND = 2 ** N;

    // Vote cap: 2**M expressed in the M+1-bit counter width.
    localparam logic [M:0]   CAP      = {1'b1, {M{1'b0}}};
    localparam logic [M:0]   CNT_ZERO = {(M+1){1'b0}};
    localparam logic [M:0]   CNT_ONE  = {{M{1'b0}}, 1'b1};
    localparam logic [N-1:0] IDX_ZERO = {N{1'b0}};
    localparam logic [N-1:0] IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t         state_r;
    logic [M:0]     count_r [NCAND];
    logic [M:0]     total_r;
    logic [N-1:0]   idx_r;
    logic [N-1:0]   best_r;
    logic [M:0]     best_cnt_r;
    logic [N-1:0]   winner_r;
    logic [M:0]     win_count_r;
    logic           vote_ready_r;
    logic           busy_r;
    logic           done_r;

    logic           accept_s;
    logic [M:0]     total_inc_s;
    logic [M:0]     cur_cnt_s;
    logic           cur_gt_s;
    logic [N-1:0]   next_best_s;
    logic [M:0]     next_best_cnt_s;

`ifdef VOTE_TIE_FLAG_EN
    logic           tie_scan_r;
    logic           tie_r;
    logic           cur_eq_s;
    logic           next_tie_s;
`endif

    // Handshake qualification and the shared scan comparator.
    always_comb begin
        accept_s        = 1'b0;
        total_inc_s     = total_r + CNT_ONE;
        cur_cnt_s       = count_r[idx_r];
        cur_gt_s        = (cur_cnt_s > best_cnt_r);
        next_best_s     = best_r;
        next_best_cnt_s = best_cnt_r;
        if ((state_r == ST_COLLECT) && vote_valid && vote_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // Strict compare keeps the earlier (lower) index on equal counts.
        if (cur_gt_s) begin
            next_best_s     = idx_r;
            next_best_cnt_s = cur_cnt_s;
        end else begin
            next_best_s     = best_r;
            next_best_cnt_s = best_cnt_r;
        end
    end

`ifdef VOTE_TIE_FLAG_EN
    // Tie tracking: a new strict leader clears it, an equal non-zero count sets it.
    always_comb begin
        cur_eq_s   = (cur_cnt_s == best_cnt_r) && (best_cnt_r != CNT_ZERO);
        next_tie_s = tie_scan_r;
        if (cur_gt_s) begin
            next_tie_s = 1'b0;
        end else if (cur_eq_s) begin
            next_tie_s = 1'b1;
        end else begin
            next_tie_s = tie_scan_r;
        end
    end
`endif

    // Election FSM: collection, counter scan, and result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_COLLECT;
            for (int i = 0; i < NCAND; i++) begin
                count_r[i] <= CNT_ZERO;
            end
            total_r      <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            best_r       <= IDX_ZERO;
            best_cnt_r   <= CNT_ZERO;
            winner_r     <= IDX_ZERO;
            win_count_r  <= CNT_ZERO;
            vote_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef VOTE_TIE_FLAG_EN
            tie_scan_r   <= 1'b0;
            tie_r        <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (accept_s) begin
                        count_r[vote] <= count_r[vote] + CNT_ONE;
                        total_r       <= total_inc_s;
                    end
                    if (close) begin
                        // A vote accepted alongside close is already counted above.
                        state_r      <= ST_SCAN;
                        busy_r       <= 1'b1;
                        vote_ready_r <= 1'b0;
                        idx_r        <= IDX_ZERO;
                        best_r       <= IDX_ZERO;
                        best_cnt_r   <= CNT_ZERO;
`ifdef VOTE_TIE_FLAG_EN
                        tie_scan_r   <= 1'b0;
`endif
                    end else if (accept_s) begin
                        vote_ready_r <= (total_inc_s < CAP);
                    end else begin
                        vote_ready_r <= (total_r < CAP);
                    end
                end
                ST_SCAN: begin
                    best_r     <= next_best_s;
                    best_cnt_r <= next_best_cnt_s;
                    idx_r      <= idx_r + IDX_ONE;
`ifdef VOTE_TIE_FLAG_EN
                    tie_scan_r <= next_tie_s;
`endif
                    if (idx_r == IDX_LAST) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        winner_r    <= next_best_s;
                        win_count_r <= next_best_cnt_s;
`ifdef VOTE_TIE_FLAG_EN
                        tie_r       <= next_tie_s;
`endif
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state_r      <= ST_COLLECT;
                        for (int i = 0; i < NCAND; i++) begin
                            count_r[i] <= CNT_ZERO;
                        end
                        total_r      <= CNT_ZERO;
                        winner_r     <= IDX_ZERO;
                        win_count_r  <= CNT_ZERO;
                        done_r       <= 1'b0;
                        vote_ready_r <= 1'b1;
`ifdef VOTE_TIE_FLAG_EN
                        tie_r        <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r      <= ST_COLLECT;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                    vote_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign vote_ready = vote_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign winner     = winner_r;
    assign win_count  = win_count_r;
    assign total      = total_r;
`ifdef VOTE_TIE_FLAG_EN
    assign tie        = tie_r;
`endif

endmodule

// File: tb/tb_vote_tally_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vote_tally_sequencer
//
// Scoreboard bench for vote_tally_sequencer (N=2, M=2). The stimulus pushes
// the hand-computed result of each election into a queue. A monitor pops an
// entry on every rising edge of done and compares it with the DUT outputs,
// including the number of busy cycles seen before done.
// -----------------------------------------------------------------------------
module tb_vote_tally_sequencer;

    localparam int N = 2;
    localparam int M = 2;

    logic         clk;
    logic         rst;
    logic         vote_valid;
    logic [N-1:0] vote;
    logic         vote_ready;
    logic         close;
    logic         start;
    logic         busy;
    logic         done;
    logic [N-1:0] winner;
    logic [M:0]   win_count;
    logic [M:0]   total;
`ifdef VOTE_TIE_FLAG_EN
    logic         tie;
`endif

    vote_tally_sequencer #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .vote_valid (vote_valid),
        .vote       (vote),
        .vote_ready (vote_ready),
        .close      (close),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .winner     (winner),
        .win_count  (win_count),
`ifdef VOTE_TIE_FLAG_EN
        .total      (total),
        .tie        (tie)
`else
        .total      (total)
`endif
    );

    typedef struct {
        int unsigned winner;
        int unsigned win_count;
        int unsigned total;
        int unsigned tie;
        int unsigned busy_len;
    } exp_t;

    exp_t        exp_q [$];
    int          n_tests;
    int          n_fail;
    int unsigned busy_len;
    logic        done_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int unsigned w, input int unsigned c,
                            input int unsigned t, input int unsigned ti);
        exp_t e;
        e.winner    = w;
        e.win_count = c;
        e.total     = t;
        e.tie       = ti;
        e.busy_len  = 32'd4;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
    task automatic step(input logic v, input logic [N-1:0] c, input logic cl, input logic st);
        vote_valid = v;
        vote       = c;
        close      = cl;
        start      = st;
        @(posedge clk);
        #1;
        vote_valid = 1'b0;
        close      = 1'b0;
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each completed election against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            busy_len  = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) busy_len++;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("winner", 32'(winner), e.winner);
                    check("win_count", 32'(win_count), e.win_count);
                    check("total", 32'(total), e.total);
                    check("busy_cycles", busy_len, e.busy_len);
                    check("busy_at_done", 32'(busy), 32'd0);
`ifdef VOTE_TIE_FLAG_EN
                    check("tie", 32'(tie), e.tie);
`endif
                end
                busy_len = 0;
            end
            done_prev = done;
        end
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        busy_len   = 0;
        done_prev  = 1'b0;
        rst        = 1'b1;
        vote_valid = 1'b0;
        vote       = 2'd0;
        close      = 1'b0;
        start      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. Reset state.
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_win_count", 32'(win_count), 32'd0);
        check("rst_total", 32'(total), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vote_ready", 32'(vote_ready), 32'd1);

        // 2. Votes 1,1,2,3 then close.
        push_exp(32'd1, 32'd2, 32'd4, 32'd0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        check("scan_busy", 32'(busy), 32'd1);
        check("scan_ready", 32'(vote_ready), 32'd0);
        wait_done("t2_done");
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // 3. Capacity: four votes for 0, fifth vote dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b0, 1'b0);
        check("cap_ready", 32'(vote_ready), 32'd0);
        check("cap_total", 32'(total), 32'd4);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        check("cap_drop_total", 32'(total), 32'd4);
        push_exp(32'd0, 32'd4, 32'd4, 32'd0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        wait_done("t3_done");
        // close and vote ignored in DONE
        step(1'b1, 2'd1, 1'b1, 1'b0);
        check("done_hold", 32'(done), 32'd1);
        check("done_hold_total", 32'(total), 32'd4);
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // 4. Tie: 3,2,2,3 -> lowest index wins.
        push_exp(32'd2, 32'd2, 32'd4, 32'd1);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        wait_done("t4_done");
        step(1'b0, 2'd0, 1'b0, 1'b1);

        // 5. Vote together with close, then start clears.
        push_exp(32'd2, 32'd1, 32'd1, 32'd0);
        step(1'b1, 2'd2, 1'b1, 1'b0);
        wait_done("t5_done");
        step(1'b0, 2'd0, 1'b0, 1'b1);
        check("start_total", 32'(total), 32'd0);
        check("start_done", 32'(done), 32'd0);
        check("start_ready", 32'(vote_ready), 32'd1);
        check("start_winner", 32'(winner), 32'd0);

        // 6. Reset in the second scan cycle aborts the election.
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_total", 32'(total), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(vote_ready), 32'd1);
        // Counters restart from zero: old count[1]=2 must not win.
        push_exp(32'd0, 32'd1, 32'd2, 32'd1);
        step(1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 2'd3, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b1, 1'b0);
        wait_done("t6_done");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
